// File: rtl/servo_pwm_driver.sv
// Two-channel hobby-servo PWM driver: fixed frame, pulse width linear in angle,
// angle changes applied only at frame boundaries. Optional slew limiting: SERVO_SLEW_EN.
module servo_pwm_driver #(
  parameter int CYCLES_PER_US = 50,
  parameter int PERIOD_US     = 20000,
  parameter int MIN_PULSE_US  = 500,
  parameter int US_PER_DEG    = 11,
  parameter int SLEW_STEP     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] base_in,
  input  logic [7:0] arm_in,
  output logic       base_pwm,
  output logic       arm_pwm,
  output logic [7:0] base_cur,
  output logic [7:0] arm_cur,
  output logic       frame_tick,
  output logic       settled
);

  localparam int PW = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;
  localparam int UW = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
  localparam logic [7:0] MAX_DEG = 8'd180;

  // The longest pulse must end before the frame does, or the line never goes low.
  if ((PERIOD_US <= MIN_PULSE_US + 180 * US_PER_DEG) || (SLEW_STEP < 1)) begin : g_bad_cfg
    $error("servo_pwm_driver: invalid parameter set");
  end

  logic [PW-1:0] presc;
  logic [UW-1:0] us_cnt;
  logic          us_tick;
  logic          frame_end;
  logic [7:0]    base_tgt;
  logic [7:0]    arm_tgt;
  logic [15:0]   base_width;
  logic [15:0]   arm_width;

  function automatic logic [7:0] sat_deg(input logic [7:0] deg);
    return (deg > MAX_DEG) ? MAX_DEG : deg;
  endfunction

  function automatic logic [15:0] pulse_width(input logic [7:0] deg);
    return 16'(MIN_PULSE_US) + 16'(deg) * 16'(US_PER_DEG);
  endfunction

  function automatic logic [7:0] next_angle(input logic [7:0] cur, input logic [7:0] tgt);
`ifdef SERVO_SLEW_EN
    logic [7:0] step;
    step = 8'(SLEW_STEP);
    if (tgt > cur)
      return ((tgt - cur) > step) ? cur + step : tgt;
    else
      return ((cur - tgt) > step) ? cur - step : tgt;
`else
    return (cur == tgt) ? cur : tgt;
`endif
  endfunction

  assign us_tick   = (presc == PW'(CYCLES_PER_US - 1));
  assign frame_end = us_tick && (us_cnt == UW'(PERIOD_US - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      us_cnt     <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (us_tick) begin
        presc  <= '0;
        us_cnt <= frame_end ? '0 : us_cnt + UW'(1);
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  // NOTE: non-blocking assignments make the frame_tick update below read the
  // targets held before this edge, so a load in that same cycle waits a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_tgt <= '0;
      arm_tgt  <= '0;
      base_cur <= '0;
      arm_cur  <= '0;
    end else begin
      if (load) begin
        base_tgt <= sat_deg(base_in);
        arm_tgt  <= sat_deg(arm_in);
      end
      if (frame_tick) begin
        base_cur <= next_angle(base_cur, base_tgt);
        arm_cur  <= next_angle(arm_cur, arm_tgt);
      end
    end
  end

  assign base_width = pulse_width(base_cur);
  assign arm_width  = pulse_width(arm_cur);

  // us_cnt is 0 in the frame_tick cycle, so the stale width there cannot shorten the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_pwm <= 1'b0;
      arm_pwm  <= 1'b0;
    end else begin
      base_pwm <= (32'(us_cnt) < 32'(base_width));
      arm_pwm  <= (32'(us_cnt) < 32'(arm_width));
    end
  end

  assign settled = (base_cur == base_tgt) && (arm_cur == arm_tgt);

endmodule
